// File: rtl/letter_scroller.sv
// Message buffer plus scroll and digit-refresh timing for a time-multiplexed
// 7-segment letter display; feeds one letter code and one active-low anode per cycle.
module letter_scroller #(
    parameter int unsigned NDIG       = 4,
    parameter int unsigned MSG_MAX    = 16,
    parameter int unsigned MUX_DIV    = 50000,
    parameter int unsigned SCROLL_DIV = 25000000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load_start,
    input  logic                         wr_valid,
    input  logic [4:0]                   wr_data,
    input  logic                         wr_last,
    output logic                         wr_ready,
    input  logic                         run,
    output logic [4:0]                   letter_code,
    output logic [NDIG-1:0]              an,
    output logic [$clog2(MSG_MAX+1)-1:0] msg_len,
    output logic                         showing
);

    localparam int unsigned LW = $clog2(MSG_MAX + 1);
    localparam int unsigned AW = (MSG_MAX > 1) ? $clog2(MSG_MAX) : 1;
    localparam int unsigned PW = $clog2(MSG_MAX + NDIG + 1);
    localparam int unsigned SW = PW + 1;
    localparam int unsigned DW = $clog2(NDIG);
    localparam int unsigned MW = $clog2(MUX_DIV);
    localparam int unsigned CW = $clog2(SCROLL_DIV);

    typedef enum logic [1:0] {IDLE, LOAD, SHOW} state_t;

    state_t          state, state_nxt;
    logic [LW-1:0]   len_nxt;
    logic [PW-1:0]   pos, pos_nxt;
    logic [DW-1:0]   dsel, dsel_nxt, dsel_rev;
    logic [MW-1:0]   mux_cnt, mux_nxt;
    logic [CW-1:0]   scr_cnt, scr_nxt;
    logic [NDIG-1:0] an_nxt;
    logic [4:0]      code_nxt, code_sel;
    logic [PW-1:0]   vlen;
    logic [SW-1:0]   vidx;
    logic            wr_acc;
    logic [4:0]      mem [MSG_MAX];

    always_comb begin
        state_nxt = state;
        len_nxt   = msg_len;
        pos_nxt   = pos;
        dsel_nxt  = dsel;
        mux_nxt   = mux_cnt + 1'b1;
        scr_nxt   = scr_cnt;
        an_nxt    = '1;
        code_nxt  = '0;
        wr_acc    = wr_valid & wr_ready & ~load_start;
        dsel_rev  = DW'(NDIG - 1) - dsel;

        // Virtual message = buffer followed by NDIG spaces; window index wraps at V
        vlen = PW'(msg_len) + PW'(NDIG);
        vidx = SW'(pos) + SW'(dsel);
        if (vidx >= SW'(vlen)) begin
            vidx = vidx - SW'(vlen);
        end
        code_sel = (vidx < SW'(msg_len)) ? mem[AW'(vidx)] : 5'd0;

        if (mux_cnt == MW'(MUX_DIV - 1)) begin
            mux_nxt  = '0;
            dsel_nxt = (dsel == DW'(NDIG - 1)) ? '0 : dsel + 1'b1;
        end

        case (state)
            LOAD: begin
                pos_nxt = '0;
                scr_nxt = '0;
                if (wr_acc) begin
                    len_nxt = msg_len + 1'b1;
                    if (wr_last || msg_len == LW'(MSG_MAX - 1)) begin
                        state_nxt = SHOW;
                    end
                end
            end
            SHOW: begin
                if (run) begin
                    if (scr_cnt == CW'(SCROLL_DIV - 1)) begin
                        scr_nxt = '0;
                        pos_nxt = (pos == vlen - 1'b1) ? '0 : pos + 1'b1;
                    end else begin
                        scr_nxt = scr_cnt + 1'b1;
                    end
                end
                // Spaces leave the digit dark instead of showing a decoder pattern
                if (code_sel != 5'd0) begin
                    an_nxt   = ~(NDIG'(1) << dsel_rev);
                    code_nxt = code_sel;
                end
            end
            default: begin
                pos_nxt = '0;
                scr_nxt = '0;
            end
        endcase

        if (load_start) begin
            state_nxt = LOAD;
            len_nxt   = '0;
            pos_nxt   = '0;
            scr_nxt   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            msg_len     <= '0;
            pos         <= '0;
            dsel        <= '0;
            mux_cnt     <= '0;
            scr_cnt     <= '0;
            wr_ready    <= 1'b0;
            showing     <= 1'b0;
            an          <= '1;
            letter_code <= '0;
        end else begin
            state       <= state_nxt;
            msg_len     <= len_nxt;
            pos         <= pos_nxt;
            dsel        <= dsel_nxt;
            mux_cnt     <= mux_nxt;
            scr_cnt     <= scr_nxt;
            wr_ready    <= (state_nxt == LOAD);
            showing     <= (state_nxt == SHOW);
            an          <= an_nxt;
            letter_code <= code_nxt;
        end
    end

    // Message storage needs no reset; msg_len defines which entries are valid
    always_ff @(posedge clk) begin
        if (state == LOAD && wr_acc) begin
            mem[AW'(msg_len)] <= wr_data;
        end
    end

endmodule

// File: tb/tb_letter_scroller.sv
// Directed bench for letter_scroller: load, display refresh, scroll wrap, freeze, reload, full buffer.
module tb_letter_scroller;

    logic clk = 1'b0;
    logic rst_n;

    logic       a_load, a_valid, a_last, a_ready, a_run, a_show;
    logic [4:0] a_data, a_code, a_len;
    logic [3:0] a_an;

    logic       b_load, b_valid, b_last, b_ready, b_run, b_show;
    logic [4:0] b_data, b_code;
    logic [3:0] b_an;
    logic [2:0] b_len;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    letter_scroller #(.NDIG(4), .MSG_MAX(16), .MUX_DIV(4), .SCROLL_DIV(64)) dut_a (
        .clk(clk), .rst_n(rst_n), .load_start(a_load), .wr_valid(a_valid),
        .wr_data(a_data), .wr_last(a_last), .wr_ready(a_ready), .run(a_run),
        .letter_code(a_code), .an(a_an), .msg_len(a_len), .showing(a_show)
    );

    letter_scroller #(.NDIG(4), .MSG_MAX(4), .MUX_DIV(4), .SCROLL_DIV(64)) dut_b (
        .clk(clk), .rst_n(rst_n), .load_start(b_load), .wr_valid(b_valid),
        .wr_data(b_data), .wr_last(b_last), .wr_ready(b_ready), .run(b_run),
        .letter_code(b_code), .an(b_an), .msg_len(b_len), .showing(b_show)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Collects one 16-cycle refresh frame of dut_a: code per digit (k=0 in bits 4:0)
    task automatic sample_frame(output logic [19:0] codes, output int lit, output int bad);
        logic [3:0] seen;
        int k;
        codes = '0;
        seen  = '0;
        lit   = 0;
        bad   = 0;
        for (int c = 0; c < 16; c++) begin
            step(1);
            k = -1;
            case (a_an)
                4'b1111: if (a_code !== 5'd0) bad++;
                4'b0111: k = 0;
                4'b1011: k = 1;
                4'b1101: k = 2;
                4'b1110: k = 3;
                default: bad++;
            endcase
            if (k >= 0) begin
                lit++;
                if (seen[k] && codes[k*5 +: 5] !== a_code) bad++;
                seen[k] = 1'b1;
                codes[k*5 +: 5] = a_code;
            end
        end
    endtask

    task automatic scroll(input int ticks);
        a_run = 1'b1;
        step(64 * ticks);
        a_run = 1'b0;
        step(2);
    endtask

    task automatic test_reset;
        int waited;
        rst_n = 1'b0;
        a_load = 0; a_valid = 0; a_last = 0; a_run = 0; a_data = '0;
        b_load = 0; b_valid = 0; b_last = 0; b_run = 0; b_data = '0;
        step(3);
        n_tests++; if (a_an !== 4'hf) begin n_fail++; $display("FAIL rst_an: got %b want 1111", a_an); end
        n_tests++; if (a_code !== 5'd0) begin n_fail++; $display("FAIL rst_code: got %0d want 0", a_code); end
        n_tests++; if (a_ready !== 1'b0 || a_show !== 1'b0) begin n_fail++; $display("FAIL rst_flags: ready %b show %b want 0 0", a_ready, a_show); end
        n_tests++; if (a_len !== 5'd0 || b_len !== 3'd0) begin n_fail++; $display("FAIL rst_len: got %0d/%0d want 0/0", a_len, b_len); end
        rst_n = 1'b1;
        step(1);
        a_load = 1; step(1); a_load = 0;
        a_valid = 1; a_data = 5'd2; a_last = 1; step(1);
        a_valid = 0; a_last = 0;
        waited = 0;
        while (a_an === 4'hf && waited < 20) begin
            step(1);
            waited++;
        end
        n_tests++; if (a_an !== 4'b0111 || a_code !== 5'd2) begin n_fail++; $display("FAIL pre_rst_lit: an %b code %0d want 0111 2", a_an, a_code); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (a_an !== 4'hf || a_code !== 5'd0) begin n_fail++; $display("FAIL async_rst_disp: an %b code %0d want 1111 0", a_an, a_code); end
        n_tests++; if (a_show !== 1'b0 || a_ready !== 1'b0 || a_len !== 5'd0) begin n_fail++; $display("FAIL async_rst_state: show %b ready %b len %0d want 0 0 0", a_show, a_ready, a_len); end
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_load_display;
        logic [4:0]  hello [5];
        logic [19:0] codes;
        int lit, bad;
        hello = '{5'd8, 5'd5, 5'd10, 5'd10, 5'd12};
        a_run = 0;
        a_load = 1; step(1); a_load = 0;
        n_tests++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL load_ready: got %b want 1", a_ready); end
        for (int i = 0; i < 5; i++) begin
            a_valid = 1; a_data = hello[i]; a_last = (i == 4);
            step(1);
        end
        a_valid = 0; a_last = 0;
        n_tests++; if (a_len !== 5'd5 || a_show !== 1'b1 || a_ready !== 1'b0) begin n_fail++; $display("FAIL hello_state: len %0d show %b ready %b want 5 1 0", a_len, a_show, a_ready); end
        step(2);
        sample_frame(codes, lit, bad);
        n_tests++; if (codes !== {5'd10, 5'd10, 5'd5, 5'd8}) begin n_fail++; $display("FAIL hello_frame: got %h want %h", codes, {5'd10, 5'd10, 5'd5, 5'd8}); end
        n_tests++; if (lit != 16 || bad != 0) begin n_fail++; $display("FAIL hello_refresh: lit %0d bad %0d want 16 0", lit, bad); end
    endtask

    task automatic test_scroll_wrap;
        logic [19:0] codes;
        int lit, bad;
        scroll(1);
        sample_frame(codes, lit, bad);
        n_tests++; if (codes !== {5'd12, 5'd10, 5'd10, 5'd5} || bad != 0) begin n_fail++; $display("FAIL scroll1: got %h bad %0d want %h", codes, bad, {5'd12, 5'd10, 5'd10, 5'd5}); end
        scroll(4);
        sample_frame(codes, lit, bad);
        n_tests++; if (lit != 0 || bad != 0) begin n_fail++; $display("FAIL scroll5_dark: lit %0d bad %0d want 0 0", lit, bad); end
        scroll(4);
        sample_frame(codes, lit, bad);
        n_tests++; if (codes !== {5'd10, 5'd10, 5'd5, 5'd8} || lit != 16) begin n_fail++; $display("FAIL scroll9_wrap: got %h lit %0d want %h 16", codes, lit, {5'd10, 5'd10, 5'd5, 5'd8}); end
    endtask

    task automatic test_freeze;
        logic [19:0] codes;
        int lit, bad;
        a_run = 1; step(20);
        a_run = 0; step(200);
        sample_frame(codes, lit, bad);
        n_tests++; if (codes !== {5'd10, 5'd10, 5'd5, 5'd8} || lit != 16 || bad != 0) begin n_fail++; $display("FAIL freeze_hold: got %h lit %0d want %h 16", codes, lit, {5'd10, 5'd10, 5'd5, 5'd8}); end
        a_run = 1; step(43);
        a_run = 0; step(2);
        sample_frame(codes, lit, bad);
        n_tests++; if (codes[4:0] !== 5'd8) begin n_fail++; $display("FAIL freeze_early: leftmost %0d want 8", codes[4:0]); end
        a_run = 1; step(1);
        a_run = 0; step(2);
        sample_frame(codes, lit, bad);
        n_tests++; if (codes[4:0] !== 5'd5) begin n_fail++; $display("FAIL freeze_resume: leftmost %0d want 5", codes[4:0]); end
    endtask

    task automatic test_reload;
        logic [19:0] codes;
        int lit, bad;
        a_load = 1; step(1); a_load = 0;
        a_last = 1; a_valid = 0; step(2);
        n_tests++; if (a_show !== 1'b0 || a_len !== 5'd0) begin n_fail++; $display("FAIL last_no_valid: show %b len %0d want 0 0", a_show, a_len); end
        a_last = 0;
        a_valid = 1; a_data = 5'd3; step(1);
        a_data = 5'd4; step(1);
        n_tests++; if (a_len !== 5'd2) begin n_fail++; $display("FAIL reload_pre: len %0d want 2", a_len); end
        a_load = 1; a_data = 5'd7; step(1);
        a_load = 0; a_valid = 0;
        n_tests++; if (a_len !== 5'd0 || a_ready !== 1'b1) begin n_fail++; $display("FAIL reload_clear: len %0d ready %b want 0 1", a_len, a_ready); end
        a_valid = 1; a_data = 5'd1; a_last = 1; step(1);
        a_valid = 0; a_last = 0;
        n_tests++; if (a_len !== 5'd1 || a_show !== 1'b1) begin n_fail++; $display("FAIL reload_show: len %0d show %b want 1 1", a_len, a_show); end
        step(2);
        sample_frame(codes, lit, bad);
        n_tests++; if (codes !== 20'd1 || lit != 4 || bad != 0) begin n_fail++; $display("FAIL reload_frame: got %h lit %0d bad %0d want 00001 4 0", codes, lit, bad); end
    endtask

    task automatic test_buffer_full;
        b_load = 1; step(1); b_load = 0;
        b_valid = 1; b_data = 5'd1; b_last = 0;
        step(3);
        n_tests++; if (b_len !== 3'd3 || b_ready !== 1'b1 || b_show !== 1'b0) begin n_fail++; $display("FAIL full_pre: len %0d ready %b show %b want 3 1 0", b_len, b_ready, b_show); end
        step(1);
        n_tests++; if (b_len !== 3'd4 || b_ready !== 1'b0 || b_show !== 1'b1) begin n_fail++; $display("FAIL full_enter: len %0d ready %b show %b want 4 0 1", b_len, b_ready, b_show); end
        step(1);
        n_tests++; if (b_len !== 3'd4) begin n_fail++; $display("FAIL full_5th: len %0d want 4", b_len); end
        b_valid = 0;
        step(2);
        n_tests++; if (b_an === 4'hf || b_code !== 5'd1) begin n_fail++; $display("FAIL full_disp: an %b code %0d want lit 1", b_an, b_code); end
    endtask

    initial begin
        test_reset();
        test_load_display();
        test_scroll_wrap();
        test_freeze();
        test_reload();
        test_buffer_full();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/letter_scroller.md
Name: letter_scroller

Overview:
- Upstream stage of the 7-segment letter decoder; owns the message and the display timing.
- Holds a short message of 5-bit letter codes, loaded over a valid/ready write port, and scrolls it right-to-left across NDIG time-multiplexed digits.
- Each cycle it presents one letter code to the decoder together with the matching active-low digit anode.

Parameters:
NDIG, 4, number of physical digits, 2..8.
MSG_MAX, 16, message buffer depth in codes, 1..32.
MUX_DIV, 50000, clk cycles per digit-refresh tick, >=2.
SCROLL_DIV, 25000000, clk cycles per scroll step, >=2.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
load_start  in  1  one-cycle pulse: discard the current message and open a load.
wr_valid  in  1  write data valid.
wr_data  in  5  letter code: 1..18 = letter, 0 = space; all other values are stored and shown unchanged.
wr_last  in  1  qualifies wr_data as the final code of the message.
wr_ready  out  1  buffer accepts a write this cycle.
run  in  1  1 = scroll advances; 0 = window frozen, refresh continues.
letter_code  out  5  code to the decoder for the digit selected by an.
an  out  NDIG  one-hot active-low anode; bit NDIG-1 is the leftmost digit.
msg_len  out  clog2(MSG_MAX+1)  number of stored codes.
showing  out  1  high in SHOW.

Behaviour:
- Reset (async assert, sync release): state IDLE, an all ones, letter_code 0, wr_ready 0, msg_len 0, showing 0, pos 0, digit select 0, both prescalers 0. Buffer contents are don't-care.
- States:
  - IDLE: display blank (an all ones).
  - LOAD: wr_ready 1, display blank.
  - SHOW: scrolling.
- load_start is honoured in any state, including mid-load. In the next cycle: state LOAD, msg_len 0, pos 0. A write in the same cycle as load_start is dropped.
- LOAD writes: on wr_valid & wr_ready, buffer[msg_len] <= wr_data and msg_len increments.
- Leaving LOAD:
  - Accepted write with wr_last = 1 -> SHOW next cycle.
  - Write that makes msg_len == MSG_MAX -> SHOW next cycle regardless of wr_last; wr_ready drops in that same next cycle.
- wr_last with wr_valid = 0 is ignored.
- No empty message: SHOW is only entered with msg_len >= 1.
- Virtual message is the buffer followed by NDIG spaces; V = msg_len + NDIG.
- Digit k (k = 0 is leftmost, driven by an[NDIG-1-k]) shows virtual index (pos + k) mod V. Indices >= msg_len are spaces.
- Refresh prescaler:
  - Free-runs 0..MUX_DIV-1 in all states; the tick is the cycle the count wraps to 0.
  - Digit select advances on each tick, k = 0..NDIG-1 then wraps to 0.
- Outputs are registered: an and letter_code update together, one cycle after the digit select changes.
- Space handling: a selected digit whose code is 0 gives an all ones and letter_code 0 (digit dark, not the decoder's default pattern).
- Scroll prescaler:
  - Counts only while SHOW & run; holds its value while run = 0.
  - Tick when it reaches SCROLL_DIV-1, then wraps to 0.
  - On tick, pos increments; pos == V-1 wraps to 0.
- A scroll tick and a refresh tick in the same cycle both take effect. The output for that cycle uses the new pos and the new digit.
- Entering SHOW: pos 0, scroll prescaler 0. The first frame shows buffer[0..NDIG-1], spaces where msg_len < NDIG.
- Reset mid-SHOW or mid-LOAD returns to IDLE; the message is lost (msg_len 0).

Test Plan:
- Reset: hold rst_n = 0, toggle clk, mid-cycle assert -> an = 4'b1111, letter_code 0, wr_ready 0, showing 0 immediately, without waiting for a clock edge.
- Load and display (NDIG = 4, MUX_DIV = 4, SCROLL_DIV = 64, run = 0):
  - Stimulus: load_start, then write 8,5,10,10,12 (H E L L O) with wr_last on 12.
  - Required: msg_len 5, showing 1.
  - Over 16 cycles the digit sequence is an = 0111/1011/1101/1110 with letter_code 8,5,10,10.
- Scroll wrap (same message, run = 1):
  - After 1 scroll tick the leftmost digit shows 5.
  - After 5 ticks the window is 4 spaces, all anodes dark.
  - After 9 ticks (V = 9) pos is 0 and the leftmost digit shows 8 again.
- Buffer full (MSG_MAX = 4): load_start, then four writes of 1 with wr_valid held and no wr_last -> wr_ready low from the cycle after the 4th write, state SHOW, msg_len 4; a 5th valid write is not accepted.
- Reload mid-load: write 3,4, then pulse load_start together with wr_valid/wr_data = 7 -> msg_len 0 next cycle, code 7 not stored; then write 1 with wr_last -> display shows 1 then three spaces.
- Freeze: in SHOW, drop run for 200 cycles -> pos unchanged and refresh continues; on run = 1 the next scroll tick comes after the remaining prescaler count, not a full SCROLL_DIV.
